// File: rtl/lcd_pkg.sv
// Shared constants for the LCD refresh controller: HD44780 command bytes,
// the raw 4-bit wake-up nibbles, FSM state encodings and timing defaults
// (cycle counts at 50 MHz).
package lcd_pkg;

    localparam int CNT_W = 26;  // wide enough for the 50M-cycle refresh wait

    localparam logic [7:0] CMD_FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ROW0     = 8'h80;
    localparam logic [7:0] CMD_ROW1     = 8'hC0;

    // Element 0 is sent first.
    localparam logic [3:0][3:0] INIT_NIBBLE = {4'h2, 4'h3, 4'h3, 4'h3};
    localparam logic [3:0][7:0] CFG_BYTE    = {CMD_CLEAR, CMD_DISP_ON, CMD_ENTRY, CMD_FUNC_SET};

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_4100US  = 205000;
    localparam int unsigned DEF_T_100US   = 5000;
    localparam int unsigned DEF_T_40US    = 2000;
    localparam int unsigned DEF_T_1640US  = 82000;
    localparam int unsigned DEF_T_GAP     = 50;
    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_E_PULSE = 12;
    localparam int unsigned DEF_T_HOLD    = 1;
    localparam int unsigned DEF_T_REFRESH = 50000000;

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, CFG, SET_ADDR, FETCH, WRITE_CHAR, FRAME_END, REFRESH_WAIT
    } lcd_state_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD, TX_POST
    } tx_state_e;

endpackage

// File: rtl/lcd_nibble_tx.sv
// Single-nibble LCD bus transfer: latch nibble/rs on start, wait T_SETUP,
// raise lcd_e for T_E_PULSE, hold data T_HOLD after the fall, then count
// post_wait cycles and pulse done. lcd_d/lcd_rs keep their value until the
// next start. start is ignored while a transfer is in flight.
// Ports: clk, reset (sync, active-high); start, nibble, rs, post_wait in;
//        done (1-cycle pulse), lcd_d, lcd_rs, lcd_e out.
// T_SETUP, T_E_PULSE and T_HOLD must be at least 1.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_E_PULSE = DEF_T_E_PULSE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       nibble,
    input  logic             rs,
    input  logic [CNT_W-1:0] post_wait,
    output logic             done,
    output logic [3:0]       lcd_d,
    output logic             lcd_rs,
    output logic             lcd_e
);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, post_q, post_d;
    logic [3:0]       d_q, d_d;
    logic             rs_q, rs_d, e_q, e_d, done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            post_q  <= '0;
            d_q     <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            post_q  <= post_d;
            d_q     <= d_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        post_d  = post_q;
        d_d     = d_q;
        rs_d    = rs_q;
        e_d     = e_q;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: if (start) begin
                d_d     = nibble;
                rs_d    = rs;
                post_d  = post_wait;
                cnt_d   = CNT_W'(T_SETUP - 1);
                state_d = TX_SETUP;
            end
            TX_SETUP: if (cnt_q == '0) begin
                e_d     = 1'b1;
                cnt_d   = CNT_W'(T_E_PULSE - 1);
                state_d = TX_PULSE;
            end else cnt_d = cnt_q - 1'b1;
            TX_PULSE: if (cnt_q == '0) begin
                e_d     = 1'b0;
                cnt_d   = CNT_W'(T_HOLD - 1);
                state_d = TX_HOLD;
            end else cnt_d = cnt_q - 1'b1;
            TX_HOLD: if (cnt_q == '0) begin
                if (post_q == '0) begin
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d   = post_q - 1'b1;
                    state_d = TX_POST;
                end
            end else cnt_d = cnt_q - 1'b1;
            TX_POST: if (cnt_q == '0) begin
                done_d  = 1'b1;
                state_d = TX_IDLE;
            end else cnt_d = cnt_q - 1'b1;
            default: state_d = TX_IDLE;
        endcase
    end

    assign done   = done_q;
    assign lcd_d  = d_q;
    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// LCD refresh controller: powers up and configures an HD44780 2x16 panel in
// 4-bit mode, then repeatedly copies 32 characters from the character BRAM
// (low nibble at BASE_ADDR+2c, high nibble at +2c+1) to the two rows and
// idles for T_REFRESH cycles between frames.
// Ports: clk, reset (sync, active-high); ram_addr/ram_en out, ram_do in
//        (1-cycle read latency); lcd_d, lcd_e, lcd_rs, lcd_rw, sf_ce0 out;
//        init_done (level), frame_done (1-cycle pulse) out.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_4100US  = DEF_T_4100US,
    parameter int unsigned T_100US   = DEF_T_100US,
    parameter int unsigned T_40US    = DEF_T_40US,
    parameter int unsigned T_1640US  = DEF_T_1640US,
    parameter int unsigned T_GAP     = DEF_T_GAP,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_E_PULSE = DEF_T_E_PULSE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_REFRESH = DEF_T_REFRESH
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] ram_addr,
    output logic        ram_en,
    input  logic [3:0]  ram_do,
    output logic [3:0]  lcd_d,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        sf_ce0,
    output logic        init_done,
    output logic        frame_done
);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d, fidx_q, fidx_d;
    logic             phase_q, phase_d;    // 0: high nibble next, 1: low nibble
    logic             issued_q, issued_d;  // nibble handed to tx, awaiting done
    logic [4:0]       c_q, c_d;
    logic [7:0]       char_q, char_d;
    logic [11:0]      ram_addr_q, ram_addr_d;
    logic             ram_en_q, ram_en_d, init_done_q, init_done_d, frame_done_q, frame_done_d;

    logic             tx_start, tx_rs, tx_done, byte_fin;
    logic [3:0]       tx_nibble;
    logic [CNT_W-1:0] tx_post;
    logic [7:0]       byte_val;
    logic             byte_rs;
    logic [5:0]       c_next;  // bit 5 flags the end of the frame

    lcd_nibble_tx #(.T_SETUP(T_SETUP), .T_E_PULSE(T_E_PULSE), .T_HOLD(T_HOLD)) u_tx (
        .clk(clk), .reset(reset), .start(tx_start), .nibble(tx_nibble), .rs(tx_rs),
        .post_wait(tx_post), .done(tx_done), .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_e(lcd_e)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= CNT_W'(T_POWERUP - 1);
            idx_q        <= '0;
            fidx_q       <= '0;
            phase_q      <= 1'b0;
            issued_q     <= 1'b0;
            c_q          <= '0;
            char_q       <= '0;
            ram_addr_q   <= BASE_ADDR;
            ram_en_q     <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            fidx_q       <= fidx_d;
            phase_q      <= phase_d;
            issued_q     <= issued_d;
            c_q          <= c_d;
            char_q       <= char_d;
            ram_addr_q   <= ram_addr_d;
            ram_en_q     <= ram_en_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Byte being sent in the byte-oriented states.
    always_comb begin
        byte_val = char_q;
        byte_rs  = 1'b1;
        case (state_q)
            CFG:      begin byte_val = CFG_BYTE[idx_q]; byte_rs = 1'b0; end
            SET_ADDR: begin byte_val = (c_q == '0) ? CMD_ROW0 : CMD_ROW1; byte_rs = 1'b0; end
            default:  ;
        endcase
    end

    assign byte_fin = issued_q && tx_done && phase_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        fidx_d       = fidx_q;
        phase_d      = phase_q;
        issued_d     = issued_q;
        c_d          = c_q;
        char_d       = char_q;
        ram_addr_d   = ram_addr_q;
        ram_en_d     = 1'b0;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        c_next       = {1'b0, c_q} + 6'd1;
        tx_start     = 1'b0;
        tx_nibble    = phase_q ? byte_val[3:0] : byte_val[7:4];
        tx_rs        = byte_rs;
        // Only the Clear command needs the long post-wait; a 0x01 data byte does not.
        tx_post      = !phase_q ? CNT_W'(T_GAP) :
                       (byte_val == CMD_CLEAR && !byte_rs) ? CNT_W'(T_1640US) : CNT_W'(T_40US);

        if (state_q == CFG || state_q == SET_ADDR || state_q == WRITE_CHAR) begin
            if (!issued_q) begin
                tx_start = 1'b1;
                issued_d = 1'b1;
            end else if (tx_done) begin
                issued_d = 1'b0;
                phase_d  = ~phase_q;
            end
        end

        case (state_q)
            PWR_WAIT: if (cnt_q == '0) begin
                idx_d   = '0;
                state_d = INIT;
            end else cnt_d = cnt_q - 1'b1;
            INIT: begin
                tx_nibble = INIT_NIBBLE[idx_q];
                tx_rs     = 1'b0;
                case (idx_q)
                    2'd0:    tx_post = CNT_W'(T_4100US);
                    2'd1:    tx_post = CNT_W'(T_100US);
                    default: tx_post = CNT_W'(T_40US);
                endcase
                if (!issued_q) begin
                    tx_start = 1'b1;
                    issued_d = 1'b1;
                end else if (tx_done) begin
                    issued_d = 1'b0;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = CFG;
                end
            end
            CFG: if (byte_fin) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    init_done_d = 1'b1;
                    c_d         = '0;
                    state_d     = SET_ADDR;
                end
            end
            SET_ADDR: if (byte_fin) begin
                fidx_d  = '0;
                state_d = FETCH;
            end
            // Registered address/enable: each address is on the bus the cycle
            // after it is chosen, its data arrives one cycle later still.
            FETCH: begin
                fidx_d = fidx_q + 2'd1;
                case (fidx_q)
                    2'd0: begin ram_addr_d = BASE_ADDR + {6'd0, c_q, 1'b1}; ram_en_d = 1'b1; end
                    2'd1: begin ram_addr_d = BASE_ADDR + {6'd0, c_q, 1'b0}; ram_en_d = 1'b1; end
                    2'd2: char_d = {ram_do, char_q[3:0]};
                    default: begin
                        char_d  = {char_q[7:4], ram_do};
                        state_d = WRITE_CHAR;
                    end
                endcase
            end
            WRITE_CHAR: if (byte_fin) begin
                c_d    = c_next[4:0];
                fidx_d = '0;
                if (c_next[5])              state_d = FRAME_END;
                else if (c_next == 6'd16)   state_d = SET_ADDR;
                else                        state_d = FETCH;
            end
            FRAME_END: begin
                frame_done_d = 1'b1;
                c_d          = '0;
                cnt_d        = CNT_W'(T_REFRESH - 1);
                state_d      = REFRESH_WAIT;
            end
            REFRESH_WAIT: if (cnt_q == '0) state_d = SET_ADDR;
                          else cnt_d = cnt_q - 1'b1;
            default: state_d = PWR_WAIT;
        endcase
    end

    assign ram_addr   = ram_addr_q;
    assign ram_en     = ram_en_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign lcd_rw     = 1'b0;
    assign sf_ce0     = 1'b1;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: BRAM model, bus monitor and a queue-based
// reference of the nibble stream and fetch addresses.
module tb_lcd_refresh_ctrl;

    localparam int TP = 100, T41 = 40, T1 = 10, T40 = 5, T164 = 20, TG = 3, TR = 200;

    logic        clk = 1'b0, reset = 1'b1;
    logic [11:0] ram_addr, ram_addr2;
    logic        ram_en, ram_en2;
    logic [3:0]  ram_do = '0, ram_do2 = '0;
    logic [3:0]  lcd_d, lcd_d2;
    logic        lcd_e, lcd_e2, lcd_rs, lcd_rs2, lcd_rw, lcd_rw2, sf_ce0, sf_ce02;
    logic        init_done, init_done2, frame_done, frame_done2;
    logic [3:0]  mem [4096];

    always #5 clk = ~clk;

    lcd_refresh_ctrl #(.BASE_ADDR(12'h000), .T_POWERUP(TP), .T_4100US(T41), .T_100US(T1),
        .T_40US(T40), .T_1640US(T164), .T_GAP(TG), .T_REFRESH(TR)) dut (
        .clk(clk), .reset(reset), .ram_addr(ram_addr), .ram_en(ram_en), .ram_do(ram_do),
        .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .sf_ce0(sf_ce0),
        .init_done(init_done), .frame_done(frame_done));

    // Second instance only exercises address wrap-around.
    lcd_refresh_ctrl #(.BASE_ADDR(12'hFFE), .T_POWERUP(TP), .T_4100US(T41), .T_100US(T1),
        .T_40US(T40), .T_1640US(T164), .T_GAP(TG), .T_REFRESH(TR)) dut2 (
        .clk(clk), .reset(reset), .ram_addr(ram_addr2), .ram_en(ram_en2), .ram_do(ram_do2),
        .lcd_d(lcd_d2), .lcd_e(lcd_e2), .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2), .sf_ce0(sf_ce02),
        .init_done(init_done2), .frame_done(frame_done2));

    always @(posedge clk) begin
        if (ram_en)  ram_do  <= mem[ram_addr];
        if (ram_en2) ram_do2 <= mem[ram_addr2];
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0, id_cyc = -1, fd_cnt = 0, const_bad = 0, hi_cnt = 0;
    logic [4:0] stream [$];
    int         rise_q [$], fall_q [$], addr_q [$], addr2_q [$];
    logic [4:0] h1 = '0, h2 = '0, pv = '0;
    logic       e_prev = 1'b0, rst_prev = 1'b1, stab_ok = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [4:0] cur;
        cur = {lcd_rs, lcd_d};
        if (sf_ce0 !== 1'b1 || lcd_rw !== 1'b0) const_bad++;
        if (ram_en) addr_q.push_back(int'(ram_addr));
        if (ram_en2 && addr2_q.size() < 4) addr2_q.push_back(int'(ram_addr2));
        if (frame_done) fd_cnt++;
        if (init_done && id_cyc < 0) id_cyc = cyc;
        if (!rst_prev) begin
            if (lcd_e && !e_prev) begin
                rise_q.push_back(cyc);
                pv      = cur;
                hi_cnt  = 1;
                stab_ok = (h1 == cur) && (h2 == cur);
            end else if (lcd_e) begin
                hi_cnt++;
                if (cur != pv) stab_ok = 1'b0;
            end else if (e_prev) begin
                stream.push_back(pv);
                fall_q.push_back(cyc);
                chk("e_width", hi_cnt, 12);
                chk("d_stable", {31'd0, stab_ok && (cur == pv)}, 1);
            end
        end
        h2 = h1; h1 = cur; e_prev = lcd_e; rst_prev = reset;
    end

    // ---------------- reference model ----------------
    logic [4:0] exp_q [$];
    int         exp_a [$];

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03); exp_q.push_back(5'h03);
        exp_q.push_back(5'h03); exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
    endtask

    // Frame from the current BRAM contents (base address 0).
    task automatic push_frame();
        push_byte(1'b0, 8'h80);
        for (int c = 0; c < 32; c++) begin
            if (c == 16) push_byte(1'b0, 8'hC0);
            push_byte(1'b1, {mem[2*c+1], mem[2*c]});
            exp_a.push_back(2*c + 1);
            exp_a.push_back(2*c);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_stream_len"}, stream.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < stream.size(); i++) begin
            chk($sformatf("%s_nibble%0d", tag, i), {27'd0, stream[i]}, {27'd0, exp_q[i]});
            if (stream[i] !== exp_q[i]) break;
        end
        chk({tag, "_addr_len"}, addr_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), addr_q[i], exp_a[i]);
            if (addr_q[i] != exp_a[i]) break;
        end
    endtask

    task automatic chk_init_timing(input string tag, input int rel);
        int r0, f11, r12;
        r0  = (rise_q.size() > 0)  ? rise_q[0]  : 0;
        f11 = (fall_q.size() > 11) ? fall_q[11] : 0;
        r12 = (rise_q.size() > 12) ? rise_q[12] : 0;
        chk({tag, "_pwr_wait_min"}, {31'd0, (r0 - rel) >= TP}, 1);
        chk({tag, "_pwr_wait_max"}, {31'd0, (r0 - rel) <= TP + 20}, 1);
        chk({tag, "_clear_gap"}, {31'd0, (r12 - f11) >= T164}, 1);
        chk({tag, "_init_done_after_clear"}, {31'd0, id_cyc >= f11 + T164}, 1);
        chk({tag, "_init_done_before_data"}, {31'd0, id_cyc >= 0 && id_cyc <= r12}, 1);
    endtask

    task automatic wait_fd(input int n);
        for (int i = 0; i < 20000 && fd_cnt < n; i++) @(negedge clk);
        chk($sformatf("frame_done_reached_%0d", n), {31'd0, fd_cnt >= n}, 1);
    endtask

    task automatic clear_obs();
        stream.delete(); rise_q.delete(); fall_q.delete(); addr_q.delete();
        exp_q.delete(); exp_a.delete();
        fd_cnt = 0; id_cyc = -1;
    endtask

    task automatic rand_mem();
        for (int a = 0; a < 64; a++) mem[a] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int rel, to;
        logic [7:0] b;
        for (int a = 0; a < 4096; a++) mem[a] = 4'(a * 7);
        for (int c = 0; c < 32; c++) begin
            b = (c < 16) ? 8'(8'h41 + c) : (c < 31) ? 8'(8'h61 + c - 16) : 8'h7C;
            mem[2*c]   = b[3:0];
            mem[2*c+1] = b[7:4];
        end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lcd_e", {31'd0, lcd_e}, 0);
        chk("rst_lcd_rs", {31'd0, lcd_rs}, 0);
        chk("rst_lcd_d", {28'd0, lcd_d}, 0);
        chk("rst_ram_en", {31'd0, ram_en}, 0);
        chk("rst_ram_addr", {20'd0, ram_addr}, 32'h000);
        chk("rst_ram_addr_base", {20'd0, ram_addr2}, 32'hFFE);
        chk("rst_init_done", {31'd0, init_done}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);

        // phase A: init + two frames, BRAM rewritten between them
        clear_obs();
        push_init();
        push_frame();
        @(posedge clk); #1 reset = 1'b0;
        rel = cyc;
        wait_fd(1);
        chk("frame_done_once", fd_cnt, 1);
        chk_init_timing("A", rel);
        rand_mem();
        push_frame();
        wait_fd(2);
        cmp_all("A");
        chk("wrap_len", addr2_q.size(), 4);
        chk("wrap_addr0", (addr2_q.size() > 0) ? addr2_q[0] : -1, 32'hFFF);
        chk("wrap_addr1", (addr2_q.size() > 1) ? addr2_q[1] : -1, 32'hFFE);
        chk("wrap_addr2", (addr2_q.size() > 2) ? addr2_q[2] : -1, 32'h001);
        chk("wrap_addr3", (addr2_q.size() > 3) ? addr2_q[3] : -1, 32'h000);

        // phase B: reset during the char-5 strobe of the third frame
        clear_obs();
        rand_mem();
        to = 0;
        while (stream.size() < 12 && to < 20000) begin @(negedge clk); to++; end
        while (!lcd_e && to < 20000) begin @(negedge clk); to++; end
        chk("reach_char5_strobe", {31'd0, to < 20000}, 1);
        chk("char5_is_data", {31'd0, lcd_rs}, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_lcd_e", {31'd0, lcd_e}, 0);
        chk("midrst_init_done", {31'd0, init_done}, 0);
        chk("midrst_ram_en", {31'd0, ram_en}, 0);
        clear_obs();
        push_init();
        push_frame();
        reset = 1'b0;
        rel = cyc;
        wait_fd(1);
        chk_init_timing("B", rel);
        cmp_all("B");

        chk("const_pins", const_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
